player_sprite_drawer: RTL



---
 rtl/player_sprite_drawer_if.sv | 29 ++
 rtl/player_sprite_drawer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/player_sprite_drawer_if.sv
// Move-request handshake, framebuffer write port and committed-position bus of the sprite drawer.
interface player_sprite_drawer_if #(
    parameter int unsigned nX          = 10,
    parameter int unsigned nY          = 9,
    parameter int unsigned COLOR_DEPTH = 9
);
    logic                   move_req;
    logic [nX-1:0]          move_x;
    logic [nY-1:0]          move_y;
    logic                   move_ready;
    logic                   busy;
    logic                   done;
    logic                   wr_en;
    logic [nX-1:0]          wr_x;
    logic [nY-1:0]          wr_y;
    logic [COLOR_DEPTH-1:0] wr_color;
    logic [nX-1:0]          player_x;
    logic [nY-1:0]          player_y;

    modport master (
        output move_req, move_x, move_y,
        input  move_ready, busy, done, wr_en, wr_x, wr_y, wr_color, player_x, player_y
    );

    modport slave (
        input  move_req, move_x, move_y,
        output move_ready, busy, done, wr_en, wr_x, wr_y, wr_color, player_x, player_y
    );
endinterface

// File: rtl/player_sprite_drawer.sv
// Player sprite framebuffer writer: erases the old square and draws the new one during
// vertical blank, one pixel per clock, then commits the new position.
module player_sprite_drawer #(
    parameter int unsigned            SIZE         = 8,
    parameter int unsigned            COLOR_DEPTH  = 9,
    parameter int unsigned            nX           = 10,
    parameter int unsigned            nY           = 9,
    parameter int unsigned            COLS         = 640,
    parameter int unsigned            ROWS         = 480,
    parameter logic [COLOR_DEPTH-1:0] PLAYER_COLOR = 9'b000_111_000,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = 9'b000_000_000,
    parameter int unsigned            INIT_X       = 320,
    parameter int unsigned            INIT_Y       = 240
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic                    frame_tick,
    player_sprite_drawer_if.slave   bus
);
    localparam int unsigned CW = $clog2(SIZE);
    localparam int unsigned NW = 2 * CW;
    localparam int unsigned XW = nX + 1;
    localparam int unsigned YW = nY + 1;
    localparam logic [NW-1:0] LAST = NW'(SIZE * SIZE - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WAIT, S_ERASE, S_DRAW} state_e;

    state_e                 state_q, state_d;
    logic [NW-1:0]          cnt_q, cnt_d;
    logic [nX-1:0]          tgt_x_q, tgt_x_d, px_q, px_d, wr_x_q, wr_x_d;
    logic [nY-1:0]          tgt_y_q, tgt_y_d, py_q, py_d, wr_y_q, wr_y_d;
    logic [COLOR_DEPTH-1:0] wr_col_q, wr_col_d;
    logic                   wr_en_q, wr_en_d, done_q, done_d;

    logic                   emit;
    logic [nX-1:0]          emit_bx;
    logic [nY-1:0]          emit_by;
    logic [COLOR_DEPTH-1:0] emit_color;
    logic [NW-1:0]          emit_idx;
    logic [XW-1:0]          sum_x;
    logic [YW-1:0]          sum_y;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            tgt_x_q  <= '0;
            tgt_y_q  <= '0;
            px_q     <= nX'(INIT_X);
            py_q     <= nY'(INIT_Y);
            wr_en_q  <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_col_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_x_q  <= tgt_x_d;
            tgt_y_q  <= tgt_y_d;
            px_q     <= px_d;
            py_q     <= py_d;
            wr_en_q  <= wr_en_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            wr_col_q <= wr_col_d;
            done_q   <= done_d;
        end
    end

    // The pixel written next cycle is chosen here, so the first scan write lands right
    // after the frame_tick edge. ERASE/DRAW end when the counter has wrapped back to 0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        px_d       = px_q;
        py_d       = py_q;
        wr_en_d    = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_col_d   = wr_col_q;
        done_d     = 1'b0;
        emit       = 1'b0;
        emit_bx    = px_q;
        emit_by    = py_q;
        emit_color = PLAYER_COLOR;
        emit_idx   = cnt_q;

        unique case (state_q)
            S_INIT: begin
                emit  = 1'b1;
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.move_req) begin
                    if (bus.move_x == px_q && bus.move_y == py_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_x_d = bus.move_x;
                        tgt_y_d = bus.move_y;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (frame_tick) begin
                    state_d    = S_ERASE;
                    emit       = 1'b1;
                    emit_color = BG_COLOR;
                    emit_idx   = '0;
                    cnt_d      = NW'(1);
                end
            end
            S_ERASE: begin
                emit = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAW;
                    emit_bx = tgt_x_q;
                    emit_by = tgt_y_q;
                    cnt_d   = NW'(1);
                end else begin
                    emit_color = BG_COLOR;
                    cnt_d      = cnt_q + NW'(1);
                end
            end
            S_DRAW: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    px_d    = tgt_x_q;
                    py_d    = tgt_y_q;
                    done_d  = 1'b1;
                end else begin
                    emit    = 1'b1;
                    emit_bx = tgt_x_q;
                    emit_by = tgt_y_q;
                    cnt_d   = cnt_q + NW'(1);
                end
            end
            default: state_d = S_INIT;
        endcase

        // Off-screen pixels still consume a scan slot but never strobe the write port.
        sum_x = XW'(emit_bx) + XW'(emit_idx[CW-1:0]);
        sum_y = YW'(emit_by) + YW'(emit_idx[NW-1:CW]);
        if (emit && sum_x < XW'(COLS) && sum_y < YW'(ROWS)) begin
            wr_en_d  = 1'b1;
            wr_x_d   = sum_x[nX-1:0];
            wr_y_d   = sum_y[nY-1:0];
            wr_col_d = emit_color;
        end
    end

    assign bus.move_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_x       = wr_x_q;
    assign bus.wr_y       = wr_y_q;
    assign bus.wr_color   = wr_col_q;
    assign bus.player_x   = px_q;
    assign bus.player_y   = py_q;
endmodule
